bounded_sampler_array: RTL

- NUM_CH independent bounded up-counters. Each channel has a counter x, a loadable bound n and a sample register m.
- While x < n, a running channel increments x once per cycle. When its sel bit is high, m captures the pre-increment x.
- Adds features the single-channel block lacks: runtime bound load, run/pause, wrap mode with a wrap counter, and a done flag.
- Sits in the arithmetic-case property suite. Per channel it must satisfy (x < n) || (m < n).

---
 rtl/bounded_sampler_pkg.sv | 27 ++
 rtl/bounded_sampler_ch.sv | 130 +++++++++++++
 rtl/bounded_sampler_chk.sv | 27 ++
 rtl/bounded_sampler_array.sv | 56 +++++
 4 files changed

// File: rtl/bounded_sampler_pkg.sv
// bounded_sampler_pkg
//   Shared types and helpers for the bounded sampler array.
//   - state_t     : per-channel FSM encoding (IDLE, COUNT, DONE).
//   - MAX_W       : widest bound the clamp helper can handle.
//   - clamp_bound : maps a zero bound to 1 so a channel always has n >= 1.
package bounded_sampler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_W = 64;

  // A bound of zero would leave no legal x < n, so it is promoted to one.
  function automatic logic [MAX_W-1:0] clamp_bound(input logic [MAX_W-1:0] value);
    logic [MAX_W-1:0] res;
    if (value == {MAX_W{1'b0}}) begin
      res = {{(MAX_W-1){1'b0}}, 1'b1};
    end else begin
      res = value;
    end
    return res;
  endfunction

endpackage

// File: rtl/bounded_sampler_ch.sv
// bounded_sampler_ch
//   One channel: bounded up-counter x, loadable bound n, sample register m,
//   saturating wrap counter and IDLE/COUNT/DONE state machine.
//   Ports:
//     clk, rst_n      clock, async active-low reset
//     load_en_i       load bound (clears x, m, wrap count; returns to IDLE)
//     load_bound_i    bound value to load (0 is treated as 1)
//     run_i           count enable
//     sel_i           sample enable (m captures pre-increment x)
//     wrap_i          0 = hold at n, 1 = restart from 0 when run
//     x_o, n_o, m_o   counter, bound, sample
//     wrap_cnt_o      saturating count of restarts
//     done_o          registered (state == DONE)
module bounded_sampler_ch
  import bounded_sampler_pkg::*;
#(
  parameter int WIDTH       = 19,
  parameter int RESET_BOUND = 200,
  parameter int WRAP_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en_i,
  input  logic [WIDTH-1:0]  load_bound_i,
  input  logic              run_i,
  input  logic              sel_i,
  input  logic              wrap_i,
  output logic [WIDTH-1:0]  x_o,
  output logic [WIDTH-1:0]  n_o,
  output logic [WIDTH-1:0]  m_o,
  output logic [WRAP_W-1:0] wrap_cnt_o,
  output logic              done_o
);

  state_t              state_q, state_d;
  logic [WIDTH-1:0]    x_q, x_d;
  logic [WIDTH-1:0]    n_q, n_d;
  logic [WIDTH-1:0]    m_q, m_d;
  logic [WRAP_W-1:0]   wc_q, wc_d;
  logic                done_q;
  logic [WIDTH-1:0]    x_inc;

  // Next-state logic: load has priority over everything else in the channel.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    n_d     = n_q;
    m_d     = m_q;
    wc_d    = wc_q;
    // Cannot overflow: increments only happen while x < n.
    x_inc   = x_q + {{(WIDTH-1){1'b0}}, 1'b1};
    if (load_en_i) begin
      n_d     = WIDTH'(clamp_bound(MAX_W'(load_bound_i)));
      x_d     = {WIDTH{1'b0}};
      m_d     = {WIDTH{1'b0}};
      wc_d    = {WRAP_W{1'b0}};
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          // Entering COUNT costs one cycle; the first increment follows it.
          if (run_i) begin
            state_d = COUNT;
          end else begin
            state_d = IDLE;
          end
        end
        COUNT: begin
          if (run_i && (x_q < n_q)) begin
            x_d = x_inc;
            if (sel_i) begin
              m_d = x_q;
            end else begin
              m_d = m_q;
            end
            if (x_inc == n_q) begin
              state_d = DONE;
            end else begin
              state_d = COUNT;
            end
          end else begin
            state_d = COUNT;
          end
        end
        DONE: begin
          if (wrap_i && run_i) begin
            x_d     = {WIDTH{1'b0}};
            state_d = COUNT;
            if (wc_q != {WRAP_W{1'b1}}) begin
              wc_d = wc_q + {{(WRAP_W-1){1'b0}}, 1'b1};
            end else begin
              wc_d = wc_q;
            end
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Channel state registers; done is registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      x_q     <= {WIDTH{1'b0}};
      n_q     <= WIDTH'(RESET_BOUND);
      m_q     <= {WIDTH{1'b0}};
      wc_q    <= {WRAP_W{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      n_q     <= n_d;
      m_q     <= m_d;
      wc_q    <= wc_d;
      done_q  <= (state_d == DONE);
    end
  end

  assign x_o        = x_q;
  assign n_o        = n_q;
  assign m_o        = m_q;
  assign wrap_cnt_o = wc_q;
  assign done_o     = done_q;

endmodule

// File: rtl/bounded_sampler_chk.sv
// bounded_sampler_chk
//   Concurrent property checker for the sampler array outputs.
//   Ports: clk, rst_n, packed x_i / n_i / m_i buses (channel i at [i*WIDTH +: WIDTH]).
//   Per channel: (x < n) || (m < n), x <= n, m < n.
module bounded_sampler_chk #(
  parameter int WIDTH  = 19,
  parameter int NUM_CH = 4
) (
  input logic                     clk,
  input logic                     rst_n,
  input logic [NUM_CH*WIDTH-1:0]  x_i,
  input logic [NUM_CH*WIDTH-1:0]  n_i,
  input logic [NUM_CH*WIDTH-1:0]  m_i
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chk
    logic [WIDTH-1:0] x_s, n_s, m_s;
    assign x_s = x_i[g*WIDTH +: WIDTH];
    assign n_s = n_i[g*WIDTH +: WIDTH];
    assign m_s = m_i[g*WIDTH +: WIDTH];

    a_inv: assert property (@(posedge clk) disable iff (!rst_n) (x_s < n_s) || (m_s < n_s));
    a_x_le_n: assert property (@(posedge clk) disable iff (!rst_n) x_s <= n_s);
    a_m_lt_n: assert property (@(posedge clk) disable iff (!rst_n) m_s < n_s);
  end

endmodule

// File: rtl/bounded_sampler_array.sv
// bounded_sampler_array
//   NUM_CH independent bounded sampler channels with packed outputs.
//   Ports:
//     clk, rst_n            clock, async active-low reset
//     load_en[NUM_CH]       per-channel bound load strobe
//     load_bound[WIDTH]     bound shared by all channels
//     run[NUM_CH]           per-channel count enable
//     sel[NUM_CH]           per-channel sample enable
//     wrap                  global mode: 0 = hold at n, 1 = restart from 0
//     x_o, n_o, m_o         packed counters / bounds / samples
//     wrap_cnt_o            packed wrap counters
//     done_o[NUM_CH]        per-channel done flag
module bounded_sampler_array
  import bounded_sampler_pkg::*;
#(
  parameter int WIDTH       = 19,
  parameter int NUM_CH      = 4,
  parameter int RESET_BOUND = 200,
  parameter int WRAP_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_CH-1:0]        load_en,
  input  logic [WIDTH-1:0]         load_bound,
  input  logic [NUM_CH-1:0]        run,
  input  logic [NUM_CH-1:0]        sel,
  input  logic                     wrap,
  output logic [NUM_CH*WIDTH-1:0]  x_o,
  output logic [NUM_CH*WIDTH-1:0]  n_o,
  output logic [NUM_CH*WIDTH-1:0]  m_o,
  output logic [NUM_CH*WRAP_W-1:0] wrap_cnt_o,
  output logic [NUM_CH-1:0]        done_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bounded_sampler_ch #(
      .WIDTH       (WIDTH),
      .RESET_BOUND (RESET_BOUND),
      .WRAP_W      (WRAP_W)
    ) u_ch (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_en_i    (load_en[g]),
      .load_bound_i (load_bound),
      .run_i        (run[g]),
      .sel_i        (sel[g]),
      .wrap_i       (wrap),
      .x_o          (x_o[g*WIDTH +: WIDTH]),
      .n_o          (n_o[g*WIDTH +: WIDTH]),
      .m_o          (m_o[g*WIDTH +: WIDTH]),
      .wrap_cnt_o   (wrap_cnt_o[g*WRAP_W +: WRAP_W]),
      .done_o       (done_o[g])
    );
  end

endmodule
